pipe_ram_access_ctrl: RTL
=========================

// Module: pipe_ram_access_ctrl
// PURPOSE
//   Command front-end for the 2-cycle pipelined distributed RAM (512x4, ports we/addr/di/do).
//   Accepts read/write commands on a valid/ready channel, drives the RAM ports from registers,
//   tracks read latency and returns read data on a valid/ready response channel.
//   Credit-based: never accepts a read without guaranteed space in the response FIFO.
//   Optional post-reset clear sweep writes CLEAR_VAL to every RAM word.
// PARAMETERS
//   ADDR_W      9   RAM address width (2**ADDR_W words)
//   DATA_W      4   RAM data width
//   FIFO_DEPTH  4   response FIFO entries, power of 2, >=4 (4 = full read throughput)
//   CLEAR_EN    1   1: clear sweep after reset and on clear_req; 0: reset enters RUN directly
//   CLEAR_VAL   0   DATA_W value written during clear sweep
// PORTS
//   clk        in   1       clock, all logic on rising edge
//   rst        in   1       asynchronous reset, active-high
//   cmd_valid  in   1       command present
//   cmd_ready  out  1       command accepted when cmd_valid & cmd_ready at clk edge
//   cmd_we     in   1       1 = write, 0 = read
//   cmd_addr   in   ADDR_W  command address
//   cmd_wdata  in   DATA_W  write data (ignored for reads)
//   rsp_valid  out  1       read data available
//   rsp_ready  in   1       consumer takes rsp_data when rsp_valid & rsp_ready
//   rsp_data   out  DATA_W  read data, in command order
//   clear_req  in   1       request new clear sweep (single-cycle pulse, RUN only)
//   clear_busy out  1       1 while in CLEAR state
//   ram_we     out  1       to RAM we (registered)
//   ram_addr   out  ADDR_W  to RAM addr (registered)
//   ram_di     out  DATA_W  to RAM di (registered)
//   ram_do     in   DATA_W  from RAM do
// BEHAVIOUR
//   Reset: ram_we=0, ram_addr=0, ram_di=0, rsp_valid=0, FIFO empty, in-flight cleared,
//     clear counter=0; state=CLEAR if CLEAR_EN else RUN. cmd_ready=0 while rst high.
//   FSM: CLEAR -> RUN when counter = 2**ADDR_W-1 written (counter wraps to 0);
//     RUN -> CLEAR on clear_req (CLEAR_EN=1, ignored otherwise); no other transitions.
//   CLEAR: each cycle ram_we=1, ram_addr=counter, ram_di=CLEAR_VAL; counter+1;
//     cmd_ready=0; clear_busy=1; sweep = 2**ADDR_W cycles. Reads already in flight
//     still complete and are delivered (RAM pipe_reg captured before we rises).
//   RUN: cmd_ready = credit_ok, independent of cmd_we/cmd_valid.
//     credit_ok = (fifo_count + inflight - pop) < FIFO_DEPTH, pop = rsp_valid & rsp_ready.
//   Accepted command at edge E0: ram_we<=cmd_we, ram_addr<=cmd_addr, ram_di<=cmd_wdata.
//     No command accepted: ram_we<=0 (RAM performs harmless read of held addr).
//   Read latency: accept at E0, RAM pipe_reg at E1, ram_do valid after E2, FIFO push at E3;
//     rsp_valid high from E3 (3 cycles). 3-bit valid shift register tags real reads only.
//   Write then read of same address on consecutive cycles returns new data (no hazard).
//   Responses strictly in command order; FIFO never overflows (credit guarantee);
//     push and pop in same cycle keep count unchanged; pop on empty impossible.
//   rsp_data = FIFO head (first-word-fall-through), stable while rsp_valid & !rsp_ready.
//   Reset mid-operation: in-flight reads and FIFO contents discarded; RAM contents untouched
//     by reset itself, then re-cleared if CLEAR_EN.
// TESTING
//   Reset, CLEAR_EN=1: clear_busy=1 for 512 cycles, ram_we=1 addr 0..511 di=0, then cmd_ready=1.
//   Write addr 0x1A0 data 0xB, next cycle read 0x1A0 -> rsp_valid 3 cycles after accept, rsp_data=0xB.
//   Back-to-back reads 0..15, rsp_ready=1 -> cmd_ready never drops, 16 responses in order, 1/cycle.
//   rsp_ready=0, stream reads -> exactly FIFO_DEPTH accepted, cmd_ready=0, no loss on release.
//   clear_req with 2 reads in flight -> both reads return pre-clear data, then full sweep.
//   rst asserted with 3 reads in flight -> rsp_valid=0 at once, no stale responses after release.

Source files
------------

// File: rtl/pipe_ram_access_ctrl.sv
// Command front-end for a 2-cycle pipelined RAM: registered RAM drive, read-latency
// tracking, credit-protected response FIFO and an optional post-reset clear sweep.
module pipe_ram_access_ctrl #(
  parameter int                 ADDR_W     = 9,
  parameter int                 DATA_W     = 4,
  parameter int                 FIFO_DEPTH = 4,
  parameter int                 CLEAR_EN   = 1,
  parameter logic [DATA_W-1:0]  CLEAR_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Holds fifo_count + inflight (at most FIFO_DEPTH + 3) without overflow.
  localparam int CNT_W = PTR_W + 2;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [2:0]        rd_vld;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  occupancy;

  logic push;
  logic pop;
  logic accept;
  logic credit_ok;

  assign inflight  = CNT_W'(rd_vld[0]) + CNT_W'(rd_vld[1]) + CNT_W'(rd_vld[2]);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = rd_vld[2];
  // Every in-flight read already owns a FIFO slot, so accepting only below depth can never overflow.
  assign occupancy = fifo_count + inflight - CNT_W'(pop);
  assign credit_ok = occupancy < CNT_W'(FIFO_DEPTH);

  assign cmd_ready  = !rst && (state == ST_RUN) && credit_ok;
  assign accept     = cmd_valid & cmd_ready;
  assign clear_busy = (state == ST_CLEAR);
  assign rsp_valid  = (fifo_count != '0);
  assign rsp_data   = fifo_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RESET;
      clr_cnt  <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_di   <= '0;
      rd_vld   <= '0;
    end else begin
      rd_vld <= {rd_vld[1:0], accept & ~cmd_we};
      if (state == ST_CLEAR) begin
        ram_we   <= 1'b1;
        ram_addr <= clr_cnt;
        ram_di   <= CLEAR_VAL;
        clr_cnt  <= clr_cnt + ADDR_W'(1);
        if (clr_cnt == LAST_ADDR) begin
          state <= ST_RUN;
        end
      end else begin
        // With no command the RAM sees we=0 and just reads the held address harmlessly.
        ram_we <= accept & cmd_we;
        if (accept) begin
          ram_addr <= cmd_addr;
          ram_di   <= cmd_wdata;
        end
        if ((CLEAR_EN != 0) && clear_req) begin
          state <= ST_CLEAR;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= ram_do;
    end
  end

endmodule
